// File: rtl/aq_djpeg_infifo_if.sv
// Byte-in / word-out bus of the JPEG input staging FIFO.
// slave = the staging FIFO itself, master = the byte source plus decoder side.
interface aq_djpeg_infifo_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  Clear;
  logic [7:0]            ByteIn;
  logic                  ByteInValid;
  logic                  ByteInReady;
  logic                  ByteFlush;
  logic [31:0]           DataOut;
  logic                  DataOutEnable;
  logic                  DataOutRead;
  logic [ADDR_WIDTH:0]   Level;
  logic                  Full;

  modport slave (
    input  Clear, ByteIn, ByteInValid, ByteFlush, DataOutRead,
    output ByteInReady, DataOut, DataOutEnable, Level, Full
  );

  modport master (
    output Clear, ByteIn, ByteInValid, ByteFlush, DataOutRead,
    input  ByteInReady, DataOut, DataOutEnable, Level, Full
  );
endinterface

// File: rtl/aq_djpeg_infifo.sv
// JPEG input staging: packs bytes big-endian into 32-bit words and buffers them in a FWFT FIFO.
// Optional SOI hunter (skip bytes until FF D8) enabled by defining AQ_DJPEG_INFIFO_SOI_SYNC_EN.
module aq_djpeg_infifo #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic clk,
  input  logic rst,
  aq_djpeg_infifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [31:0]          mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]  wrPtr, rdPtr;
  logic [1:0]           pc, pcAfter, pcNext;
  logic [23:0]          packReg, packAfter, packNext;
  logic                 flushPending, flushPendingNext;
  logic                 full, empty, byteReady, byteAccept;
  logic                 pushEn, popEn, flushReq;
  logic [31:0]          pushWord;
  logic                 packByte, startSoi, flushAllowed;

  assign empty      = (wrPtr == rdPtr);
  assign full       = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                      (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
  // Ready looks only at registered state so it never combinationally depends on the pop.
  assign byteReady  = !(full && (pc == 2'd3));
  assign byteAccept = bus.ByteInValid && byteReady;
  assign popEn      = bus.DataOutRead && !empty;

`ifdef AQ_DJPEG_INFIFO_SOI_SYNC_EN
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] GOT_FF = 2'd1;
  localparam logic [1:0] PASS   = 2'd2;

  logic [1:0] huntState, huntStateNext;

  always_comb begin
    packByte      = 1'b0;
    startSoi      = 1'b0;
    huntStateNext = huntState;
    flushAllowed  = (huntState == PASS);
    if (byteAccept) begin
      case (huntState)
        HUNT: begin
          if (bus.ByteIn == 8'hFF) huntStateNext = GOT_FF;
        end
        GOT_FF: begin
          if (bus.ByteIn == 8'hD8) begin
            startSoi      = 1'b1;
            packByte      = 1'b1;
            huntStateNext = PASS;
          end else if (bus.ByteIn != 8'hFF) begin
            huntStateNext = HUNT;
          end
        end
        default: packByte = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           huntState <= HUNT;
    else if (bus.Clear) huntState <= HUNT;
    else                huntState <= huntStateNext;
  end
`else
  assign packByte     = byteAccept;
  assign startSoi     = 1'b0;
  assign flushAllowed = 1'b1;
`endif

  assign flushReq = (bus.ByteFlush || flushPending) && flushAllowed;

  always_comb begin
    pcAfter          = pc;
    packAfter        = packReg;
    pushEn           = 1'b0;
    pushWord         = 32'h0;
    if (packByte) begin
      if (startSoi) begin
        // The hunter only leaves HUNT with an empty packer, so FF D8 start a fresh word.
        packAfter = {8'hFF, 8'hD8, 8'h00};
        pcAfter   = 2'd2;
      end else begin
        case (pc)
          2'd0: begin packAfter[23:16] = bus.ByteIn; pcAfter = 2'd1; end
          2'd1: begin packAfter[15:8]  = bus.ByteIn; pcAfter = 2'd2; end
          2'd2: begin packAfter[7:0]   = bus.ByteIn; pcAfter = 2'd3; end
          default: begin
            pushEn    = 1'b1;
            pushWord  = {packReg, bus.ByteIn};
            pcAfter   = 2'd0;
            packAfter = 24'h0;
          end
        endcase
      end
    end

    pcNext           = pcAfter;
    packNext         = packAfter;
    flushPendingNext = flushPending;
    // Flush acts on the packer after this cycle's byte; a completed word leaves nothing to flush.
    if (flushReq) begin
      if (pcAfter == 2'd0) begin
        flushPendingNext = 1'b0;
      end else if (!full) begin
        pushEn           = 1'b1;
        pcNext           = 2'd0;
        packNext         = 24'h0;
        flushPendingNext = 1'b0;
        case (pcAfter)
          2'd1:    pushWord = {packAfter[23:16], PAD_BYTE, PAD_BYTE, PAD_BYTE};
          2'd2:    pushWord = {packAfter[23:8], PAD_BYTE, PAD_BYTE};
          default: pushWord = {packAfter, PAD_BYTE};
        endcase
      end else begin
        flushPendingNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      pc           <= 2'd0;
      packReg      <= 24'h0;
      flushPending <= 1'b0;
    end else if (bus.Clear) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      pc           <= 2'd0;
      packReg      <= 24'h0;
      flushPending <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PTR_ONE;
      if (popEn)  rdPtr <= rdPtr + PTR_ONE;
      pc           <= pcNext;
      packReg      <= packNext;
      flushPending <= flushPendingNext;
    end
  end

  // Storage is left unreset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (pushEn && !bus.Clear) mem[wrPtr[ADDR_WIDTH-1:0]] <= pushWord;
  end

  assign bus.DataOut       = mem[rdPtr[ADDR_WIDTH-1:0]];
  assign bus.DataOutEnable = !empty;
  assign bus.Level         = wrPtr - rdPtr;
  assign bus.Full          = full;
  assign bus.ByteInReady   = byteReady;

endmodule

// File: tb/tb_aq_djpeg_infifo.sv
// Self-checking bench for aq_djpeg_infifo: directed scenarios plus a randomized run
// against a queue-based model of the byte packer and word FIFO.
module tb_aq_djpeg_infifo;

  localparam int DEPTH = 16;
  localparam logic [7:0] PAD = 8'h00;
`ifdef AQ_DJPEG_INFIFO_SOI_SYNC_EN
  localparam bit SOI_EN = 1'b1;
`else
  localparam bit SOI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  aq_djpeg_infifo_if #(.ADDR_WIDTH(4)) bus ();

  aq_djpeg_infifo #(.ADDR_WIDTH(4), .PAD_BYTE(PAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: pending bytes of the current word, stored words, hunter progress.
  logic [7:0]  mPack[$];
  logic [31:0] mFifo[$];
  bit          mPend, mSynced, mSawFF;

  task automatic model_reset();
    mPack.delete();
    mFifo.delete();
    mPend   = 1'b0;
    mSawFF  = 1'b0;
    mSynced = !SOI_EN;
  endtask

  task automatic model_update(input logic c, input logic v, input logic [7:0] b,
                              input logic f, input logic r);
    bit wasFull, ready, wasSynced;
    if (c) begin
      model_reset();
      return;
    end
    wasFull   = (mFifo.size() == DEPTH);
    ready     = !(wasFull && mPack.size() == 3);
    wasSynced = mSynced;
    if (r && mFifo.size() > 0) void'(mFifo.pop_front());
    if (v && ready) begin
      if (mSynced) begin
        mPack.push_back(b);
        if (mPack.size() == 4) begin
          mFifo.push_back({mPack[0], mPack[1], mPack[2], mPack[3]});
          mPack.delete();
        end
      end else if (mSawFF && b == 8'hD8) begin
        mPack.push_back(8'hFF);
        mPack.push_back(8'hD8);
        mSynced = 1'b1;
      end else begin
        mSawFF = (b == 8'hFF);
      end
    end
    if ((f || mPend) && wasSynced) begin
      if (mPack.size() == 0) mPend = 1'b0;
      else if (!wasFull) begin
        mFifo.push_back({mPack[0],
                         (mPack.size() > 1) ? mPack[1] : PAD,
                         (mPack.size() > 2) ? mPack[2] : PAD,
                         PAD});
        mPack.delete();
        mPend = 1'b0;
      end else mPend = 1'b1;
    end
  endtask

  // One clock of stimulus; returns 1 ns after the edge with inputs idled.
  task automatic step(input logic c, input logic v, input logic [7:0] b,
                      input logic f, input logic r);
    bus.Clear       = c;
    bus.ByteInValid = v;
    bus.ByteIn      = b;
    bus.ByteFlush   = f;
    bus.DataOutRead = r;
    @(posedge clk);
    model_update(c, v, b, f, r);
    #1;
    bus.Clear       = 1'b0;
    bus.ByteInValid = 1'b0;
    bus.ByteIn      = 8'h00;
    bus.ByteFlush   = 1'b0;
    bus.DataOutRead = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop_word();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // With the hunter built in, push and drop an SOI word so later bytes are packed.
  task automatic sync_prefix();
    if (SOI_EN) begin
      push_byte(8'hFF); push_byte(8'hD8); push_byte(8'hFF); push_byte(8'hDB);
      pop_word();
    end
  endtask

  task automatic test_reset();
    bus.Clear = 0; bus.ByteInValid = 0; bus.ByteIn = 0; bus.ByteFlush = 0; bus.DataOutRead = 0;
    rst = 1'b0;
    model_reset();
    #23;
    tests++;
    if (bus.Level !== 5'd0 || bus.DataOutEnable !== 1'b0 || bus.Full !== 1'b0 || bus.ByteInReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got lvl=%0d en=%b full=%b rdy=%b required lvl=0 en=0 full=0 rdy=1",
               bus.Level, bus.DataOutEnable, bus.Full, bus.ByteInReady);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_prefix();
    for (int i = 0; i < 67; i++) push_byte(8'(i));
    tests++;
    if (bus.Full !== 1'b1 || bus.ByteInReady !== 1'b0) begin
      fails++;
      $display("FAIL reset_prefill: got full=%b rdy=%b required full=1 rdy=0", bus.Full, bus.ByteInReady);
    end
    #3 rst = 1'b0;
    #1;
    model_reset();
    tests++;
    if (bus.Level !== 5'd0 || bus.DataOutEnable !== 1'b0 || bus.Full !== 1'b0 || bus.ByteInReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_async: got lvl=%0d en=%b full=%b rdy=%b required lvl=0 en=0 full=0 rdy=1",
               bus.Level, bus.DataOutEnable, bus.Full, bus.ByteInReady);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset checks done");
  endtask

  task automatic test_first_word();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    push_byte(8'hFF); push_byte(8'hD8); push_byte(8'hFF);
    tests++;
    if (bus.DataOutEnable !== 1'b0) begin
      fails++;
      $display("FAIL first_word_early: got en=%b required en=0", bus.DataOutEnable);
    end
    push_byte(8'hDB);
    tests++;
    if (bus.DataOutEnable !== 1'b1 || bus.DataOut !== 32'hFFD8FFDB || bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL first_word: got en=%b data=%08h lvl=%0d required en=1 data=ffd8ffdb lvl=1",
               bus.DataOutEnable, bus.DataOut, bus.Level);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL flush_empty_packer: got lvl=%0d required lvl=1", bus.Level);
    end
    pop_word();
    tests++;
    if (bus.DataOutEnable !== 1'b0 || bus.Level !== 5'd0) begin
      fails++;
      $display("FAIL first_word_pop: got en=%b lvl=%0d required en=0 lvl=0", bus.DataOutEnable, bus.Level);
    end
    pop_word();
    tests++;
    if (bus.Level !== 5'd0) begin
      fails++;
      $display("FAIL underflow: got lvl=%0d required lvl=0", bus.Level);
    end
    $display("[TB] first word ffd8ffdb checked");
  endtask

  task automatic test_streaming();
    logic [31:0] got[$];
    logic [31:0] exp;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_prefix();
    for (int i = 0; i <= 64; i++) begin
      if (bus.DataOutEnable === 1'b1) got.push_back(bus.DataOut);
      tests++;
      if (bus.Full !== 1'b0) begin
        fails++;
        $display("FAIL stream_full: cycle %0d got full=%b required 0", i, bus.Full);
      end
      step(1'b0, (i < 64), 8'(i), 1'b0, 1'b1);
    end
    tests++;
    if (got.size() != 16) begin
      fails++;
      $display("FAIL stream_count: got %0d words required 16", got.size());
    end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      $display("[TB] stream word %0d = %08h", k, got[k]);
      tests++;
      if (got[k] !== exp) begin
        fails++;
        $display("FAIL stream_word%0d: got %08h required %08h", k, got[k], exp);
      end
    end
  endtask

  task automatic test_full_backpressure();
    logic [7:0]  bytes[68];
    logic [31:0] exp;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_prefix();
    for (int i = 0; i < 68; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 64; i++) push_byte(bytes[i]);
    tests++;
    if (bus.Full !== 1'b1 || bus.Level !== 5'd16 || bus.ByteInReady !== 1'b1) begin
      fails++;
      $display("FAIL full_64: got full=%b lvl=%0d rdy=%b required full=1 lvl=16 rdy=1",
               bus.Full, bus.Level, bus.ByteInReady);
    end
    for (int i = 64; i < 67; i++) push_byte(bytes[i]);
    tests++;
    if (bus.ByteInReady !== 1'b0) begin
      fails++;
      $display("FAIL full_ready_low: got rdy=%b required 0", bus.ByteInReady);
    end
    step(1'b0, 1'b1, bytes[67], 1'b0, 1'b1);
    tests++;
    if (bus.Full !== 1'b0 || bus.Level !== 5'd15 || bus.ByteInReady !== 1'b1) begin
      fails++;
      $display("FAIL full_pop: got full=%b lvl=%0d rdy=%b required full=0 lvl=15 rdy=1",
               bus.Full, bus.Level, bus.ByteInReady);
    end
    push_byte(bytes[67]);
    tests++;
    if (bus.Full !== 1'b1 || bus.Level !== 5'd16) begin
      fails++;
      $display("FAIL full_68th: got full=%b lvl=%0d required full=1 lvl=16", bus.Full, bus.Level);
    end
    for (int k = 1; k < 17; k++) begin
      exp = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
      tests++;
      if (bus.DataOut !== exp || bus.DataOutEnable !== 1'b1) begin
        fails++;
        $display("FAIL full_drain%0d: got en=%b data=%08h required en=1 data=%08h",
                 k, bus.DataOutEnable, bus.DataOut, exp);
      end
      pop_word();
    end
    $display("[TB] full/backpressure drained");
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_prefix();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (bus.DataOutEnable !== 1'b1 || bus.DataOut !== 32'h11223300 || bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL flush_partial: got en=%b data=%08h lvl=%0d required en=1 data=11223300 lvl=1",
               bus.DataOutEnable, bus.DataOut, bus.Level);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    tests++;
    if (bus.Level !== 5'd2) begin
      fails++;
      $display("FAIL flush_then_word: got lvl=%0d required lvl=2", bus.Level);
    end
    pop_word();
    tests++;
    if (bus.DataOut !== 32'hAABBCCDD) begin
      fails++;
      $display("FAIL flush_pc_zero: got %08h required aabbccdd", bus.DataOut);
    end
    pop_word();
    push_byte(8'h44);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    tests++;
    if (bus.DataOut !== 32'h44550000 || bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL flush_with_byte: got data=%08h lvl=%0d required data=44550000 lvl=1", bus.DataOut, bus.Level);
    end
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    step(1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
    tests++;
    if (bus.Level !== 5'd2) begin
      fails++;
      $display("FAIL flush_completing_byte: got lvl=%0d required lvl=2", bus.Level);
    end
    pop_word();
    tests++;
    if (bus.DataOut !== 32'h01020304 || bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL flush_completing_word: got data=%08h lvl=%0d required data=01020304 lvl=1", bus.DataOut, bus.Level);
    end
    pop_word();
    $display("[TB] flush checks done");
  endtask

  task automatic test_clear();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_prefix();
    for (int i = 0; i < 22; i++) push_byte(8'(8'h80 + i));
    tests++;
    if (bus.Level !== 5'd5) begin
      fails++;
      $display("FAIL clear_fill: got lvl=%0d required lvl=5", bus.Level);
    end
    step(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    tests++;
    if (bus.Level !== 5'd0 || bus.DataOutEnable !== 1'b0 || bus.ByteInReady !== 1'b1) begin
      fails++;
      $display("FAIL clear_state: got lvl=%0d en=%b rdy=%b required lvl=0 en=0 rdy=1",
               bus.Level, bus.DataOutEnable, bus.ByteInReady);
    end
    sync_prefix();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    tests++;
    if (bus.DataOut !== 32'hA1A2A3A4 || bus.Level !== 5'd1) begin
      fails++;
      $display("FAIL clear_pc: got data=%08h lvl=%0d required data=a1a2a3a4 lvl=1", bus.DataOut, bus.Level);
    end
    $display("[TB] clear checks done");
  endtask

  task automatic test_soi_sync();
    logic [7:0]  seq[8];
    logic [31:0] expWord;
    logic [4:0]  expLevel;
    seq = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'hFF, 8'hD8, 8'hE0, 8'h00};
    expWord  = SOI_EN ? 32'hFFD8E000 : 32'h12FF34FF;
    expLevel = SOI_EN ? 5'd1 : 5'd2;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_byte(seq[i]);
    tests++;
    if (bus.DataOutEnable !== 1'b1 || bus.DataOut !== expWord || bus.Level !== expLevel) begin
      fails++;
      $display("FAIL soi_sync: got en=%b data=%08h lvl=%0d required en=1 data=%08h lvl=%0d",
               bus.DataOutEnable, bus.DataOut, bus.Level, expWord, expLevel);
    end
    $display("[TB] soi sync first word %08h", bus.DataOut);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       c, v, f, r;
    logic [4:0] expLevel;
    int         rdPct, sel;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdPct = ((cyc / 250) % 2 == 0) ? 15 : 85;
      sel = int'($urandom_range(0, 99));
      b = (sel < 20) ? 8'hFF : (sel < 35) ? 8'hD8 : 8'($urandom_range(0, 255));
      c = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 99) < 75);
      f = ($urandom_range(0, 99) < 6);
      r = ($urandom_range(0, 99) < rdPct);
      if (r && mFifo.size() > 0 && !c) $display("[TB] rnd pop %08h", mFifo[0]);
      step(c, v, b, f, r);
      expLevel = 5'(mFifo.size());
      tests++;
      if (bus.Level !== expLevel || bus.Full !== (mFifo.size() == DEPTH)) begin
        fails++;
        $display("FAIL rnd_level: cycle %0d got lvl=%0d full=%b required lvl=%0d", cyc, bus.Level, bus.Full, expLevel);
      end
      tests++;
      if (bus.ByteInReady !== !(mFifo.size() == DEPTH && mPack.size() == 3)) begin
        fails++;
        $display("FAIL rnd_ready: cycle %0d got rdy=%b", cyc, bus.ByteInReady);
      end
      tests++;
      if (bus.DataOutEnable !== (mFifo.size() != 0)) begin
        fails++;
        $display("FAIL rnd_enable: cycle %0d got en=%b required %b", cyc, bus.DataOutEnable, (mFifo.size() != 0));
      end
      if (mFifo.size() != 0) begin
        tests++;
        if (bus.DataOut !== mFifo[0]) begin
          fails++;
          $display("FAIL rnd_data: cycle %0d got %08h required %08h", cyc, bus.DataOut, mFifo[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_streaming();
    test_full_backpressure();
    test_flush();
    test_clear();
    test_soi_sync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
